// File: rtl/piso_pkg.sv
// Shared types and constants for the stream serializer.
// Holds the shifter state encoding and counter sizing.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register, bit counter and frame state machine.
// Reports idle and the last-bit edge so the parent can reload.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             idle,
    output logic             last_edge,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    cnt;
    logic             at_last;

    assign at_last      = (cnt == CNT_LAST);
    assign idle         = (state == IDLE);
    assign last_edge    = (state == SHIFT) && shift_en && at_last;
    assign sreg_shifted = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]}
                                    : {sreg[WIDTH-2:0], 1'b0};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and registered-output decode
    always_comb begin
        state_next   = state;
        serial_out   = IDLE_LEVEL;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        frame_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) state_next = SHIFT;
            end
            SHIFT: begin
                serial_out   = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
                serial_valid = 1'b1;
                frame_start  = (cnt == '0);
                frame_last   = at_last;
                if (load)           state_next = SHIFT;
                else if (last_edge) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= '0;
        end else if ((state == SHIFT) && shift_en) begin
            sreg <= sreg_shifted;
            cnt  <= at_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_stream_serializer.sv
// Valid/ready word intake with a one-entry holding buffer.
// Feeds the shift core so frames run back to back.
module piso_stream_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Parallel_In,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Shift_En,
    output logic             Serial_Out,
    output logic             Serial_Valid,
    output logic             Frame_Start,
    output logic             Frame_Last,
    output logic             Busy
);

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             accept;
    logic             load;
    logic             core_idle;
    logic             core_last;

    assign In_Ready = !hold_full;
    assign accept   = In_Valid && !hold_full;
    assign load     = hold_full && (core_idle || core_last);
    assign Busy     = Serial_Valid || hold_full;

    // Holding buffer: filled on accept, drained on load
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= Parallel_In;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    piso_shift_core #(
        .WIDTH      (WIDTH),
        .LSB_FIRST  (LSB_FIRST),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_core (
        .clk          (Clk),
        .rst          (Rst),
        .load         (load),
        .load_data    (hold),
        .shift_en     (Shift_En),
        .idle         (core_idle),
        .last_edge    (core_last),
        .serial_out   (Serial_Out),
        .serial_valid (Serial_Valid),
        .frame_start  (Frame_Start),
        .frame_last   (Frame_Last)
    );

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Directed bench for the stream serializer, MSB and LSB lanes.
// Scoreboard queues hold expected bits pushed at accept time.
module tb_piso_stream_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic fs;
        logic fl;
    } exp_t;

    logic         Clk;
    logic         Rst;
    logic [W-1:0] Parallel_In;
    logic         In_Valid;
    logic         Shift_En;
    logic [1:0]   rdy;
    logic [1:0]   so;
    logic [1:0]   sv;
    logic [1:0]   fs;
    logic [1:0]   fl;
    logic [1:0]   busy;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int passed = 0;
    int valid_cnt = 0;
    int run = 0;
    int max_run = 0;

    piso_stream_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
        .Clk(Clk), .Rst(Rst), .Parallel_In(Parallel_In), .In_Valid(In_Valid),
        .In_Ready(rdy[0]), .Shift_En(Shift_En), .Serial_Out(so[0]),
        .Serial_Valid(sv[0]), .Frame_Start(fs[0]), .Frame_Last(fl[0]), .Busy(busy[0])
    );

    piso_stream_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
        .Clk(Clk), .Rst(Rst), .Parallel_In(Parallel_In), .In_Valid(In_Valid),
        .In_Ready(rdy[1]), .Shift_En(Shift_En), .Serial_Out(so[1]),
        .Serial_Valid(sv[1]), .Frame_Start(fs[1]), .Frame_Last(fl[1]), .Busy(busy[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic lane_check(input int d, input int qn);
        exp_t e;
        if (sv[d]) begin
            if (qn == 0) begin
                chk($sformatf("sb_underflow%0d", d), 1, 0);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("bit%0d", d), so[d], e.b);
                chk($sformatf("fstart%0d", d), fs[d], e.fs);
                chk($sformatf("flast%0d", d), fl[d], e.fl);
                if (Shift_En) begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end else begin
            chk($sformatf("idle_line%0d", d), so[d], 1'b0);
        end
    endtask

    // Scoreboard: push on upcoming accept, compare and pop on output
    always @(negedge Clk) begin
        if (!Rst) begin
            if (In_Valid && rdy[0]) begin
                for (int i = 0; i < W; i++) begin
                    q0.push_back('{b: Parallel_In[W-1-i], fs: (i == 0), fl: (i == W-1)});
                    q1.push_back('{b: Parallel_In[i], fs: (i == 0), fl: (i == W-1)});
                end
            end
            lane_check(0, q0.size());
            lane_check(1, q1.size());
            if (sv[0]) begin
                valid_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        logic r;
        int n;
        Parallel_In = w;
        In_Valid = 1'b1;
        n = 0;
        r = 1'b0;
        while (!r && n < 50) begin
            r = rdy[0];
            step(1);
            n++;
        end
        chk("accept_timeout", r, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy[0] && n < 100) begin
            step(1);
            n++;
        end
        chk("idle_timeout", busy[0], 1'b0);
    endtask

    task automatic clear_stats();
        valid_cnt = 0;
        run = 0;
        max_run = 0;
    endtask

    initial begin
        int n;
        logic r;
        Rst = 1'b1;
        Parallel_In = '0;
        In_Valid = 1'b0;
        Shift_En = 1'b1;
        #1;
        chk("rst_ready", rdy[0], 1'b1);
        chk("rst_out", so[0], 1'b0);
        chk("rst_valid", sv[0], 1'b0);
        chk("rst_start", fs[0], 1'b0);
        chk("rst_last", fl[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        step(2);
        Rst = 1'b0;
        step(2);

        // Single frame 0F, both bit orders, latency
        clear_stats();
        send(8'h0F);
        In_Valid = 1'b0;
        chk("lat_valid0", sv[0], 1'b0);
        chk("lat_busy", busy[0], 1'b1);
        chk("lat_ready", rdy[0], 1'b0);
        step(1);
        chk("lat_valid1", sv[0], 1'b1);
        chk("lat_start", fs[0], 1'b1);
        chk("lat_bit_lsb", so[1], 1'b1);
        wait_idle();
        chk("frame_len", valid_cnt, W);

        // Back-to-back A5, 3C
        step(2);
        clear_stats();
        send(8'hA5);
        send(8'h3C);
        chk("b2b_ready", rdy[0], 1'b0);
        chk("b2b_busy", busy[0], 1'b1);
        In_Valid = 1'b0;
        wait_idle();
        chk("b2b_run", max_run, 2 * W);
        chk("b2b_count", valid_cnt, 2 * W);

        // Back-pressure: third word waits for the reload edge
        step(2);
        clear_stats();
        send(8'h11);
        send(8'h22);
        Parallel_In = 8'h33;
        n = 0;
        r = 1'b0;
        while (!r && n < 50) begin
            r = rdy[0];
            step(1);
            n++;
        end
        chk("bp_wait", n, W);
        In_Valid = 1'b0;
        wait_idle();
        chk("bp_run", max_run, 3 * W);

        // Shift_En every third cycle
        step(2);
        clear_stats();
        Shift_En = 1'b0;
        send(8'hC3);
        In_Valid = 1'b0;
        step(1);
        for (int k = 0; k < 30; k++) begin
            Shift_En = (k % 3 == 2);
            step(1);
        end
        chk("slow_len", valid_cnt, 3 * W);
        chk("slow_busy", busy[0], 1'b0);
        Shift_En = 1'b1;

        // Reset mid-frame with a held word
        step(2);
        send(8'hFF);
        send(8'h5A);
        In_Valid = 1'b0;
        step(2);
        chk("pre_rst_valid", sv[0], 1'b1);
        Rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_valid", sv[0], 1'b0);
        chk("mid_rst_out", so[0], 1'b0);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_ready", rdy[0], 1'b1);
        chk("mid_rst_last", fl[0], 1'b0);
        step(1);
        Rst = 1'b0;
        clear_stats();
        step(20);
        chk("post_rst_idle", valid_cnt, 0);
        chk("post_rst_busy", busy[0], 1'b0);
        send(8'h96);
        In_Valid = 1'b0;
        wait_idle();
        chk("post_rst_frame", valid_cnt, W);

        step(2);
        chk("sb_empty0", q0.size(), 0);
        chk("sb_empty1", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/piso_stream_serializer.md
# piso_stream_serializer

Parametrised parallel-in/serial-out serializer. It is the next generation of the 4-bit load/shift PISO register. Each word is taken through a valid/ready handshake into a one-entry holding buffer and shifted out MSB- or LSB-first at a rate set by an external bit-enable. The holding buffer gives gapless back-to-back frames. It sits between a word-wide producer and a serial line driver or bit-rate generator.

## Interface
- WIDTH, 8, word length in bits; legal range ≥ 2
- LSB_FIRST, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first
- IDLE_LEVEL, 0, Serial_Out level when no frame is active
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  reset; asynchronous, active-high
- Parallel_In  in  WIDTH  word to serialize; sampled on the accept edge
- In_Valid  in  1  producer has a word on Parallel_In
- In_Ready  out  1  holding buffer empty; equals !hold_full
- Shift_En  in  1  bit-rate enable; the shifter advances only on edges where it is 1
- Serial_Out  out  1  current serial bit, or IDLE_LEVEL when idle
- Serial_Valid  out  1  Serial_Out carries a frame bit
- Frame_Start  out  1  first bit of a frame is on Serial_Out
- Frame_Last  out  1  last bit of a frame is on Serial_Out
- Busy  out  1  shifter active or holding buffer full

## Operation
- Accept: a rising edge where In_Valid=1 and In_Ready=1 writes Parallel_In to hold and sets hold_full.
- While In_Ready=0, Parallel_In is ignored. The producer keeps In_Valid and its data stable until acceptance.
- The shifter state machine has two states, IDLE and SHIFT, plus a bit counter cnt of width $clog2(WIDTH).
- IDLE with hold_full=1: on the next edge, independent of Shift_En, hold loads into sreg, cnt=0, state goes to SHIFT and hold_full clears.
- SHIFT, on an edge with Shift_En=1 and cnt<WIDTH-1: sreg shifts toward the output end, cnt increments.
- SHIFT, on an edge with Shift_En=1 and cnt==WIDTH-1:
  - hold_full=1: reload from hold, cnt=0, stay in SHIFT, hold_full clears. This is a gapless frame.
  - hold_full=0: go to IDLE.
- SHIFT, on an edge with Shift_En=0: no change; the current bit is held.
- Output selection:
  - Serial_Out is sreg[WIDTH-1] when LSB_FIRST=0, sreg[0] when LSB_FIRST=1, and IDLE_LEVEL in IDLE.
  - Serial_Valid = (state==SHIFT).
  - Frame_Start = SHIFT && cnt==0.
  - Frame_Last = SHIFT && cnt==WIDTH-1.
  - Busy = SHIFT || hold_full.
- All outputs decode directly from registers; there is no combinational path from an input to an output.
- Because In_Ready is !hold_full, an accept and a drain never coincide on the same edge. In_Ready rises on the cycle after a drain.

## Timing
- Reset values: state=IDLE, hold_full=0, cnt=0, sreg=0.
  - Outputs at reset: In_Ready=1, Serial_Out=IDLE_LEVEL, Serial_Valid=0, Frame_Start=0, Frame_Last=0, Busy=0.
- Latency: the first bit appears on Serial_Out one cycle after the accept edge when the shifter is idle.
- Bit duration: each bit is held from one Shift_En edge to the next. With Shift_En tied high, a frame is exactly WIDTH cycles.
- Throughput: with Shift_En tied high and the producer always valid, output is continuous with no idle cycle between frames. For WIDTH ≥ 2, hold refills before the last-bit edge.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous). The word in flight and the held word are discarded, and no partial frame resumes.
- Shift_En=1 while in IDLE has no effect.

## Structure
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT)
  - the counter-width constant function
  - the default WIDTH constant
- Sub-module piso_shift_core contains sreg, cnt, the state machine and the output decode.
  - Its inputs are a load strobe, the load data and Shift_En.
  - It reports a last-bit-edge indication upward.
- The top level contains the holding buffer, the handshake and the Busy logic.

## Test plan
- WIDTH=8, LSB_FIRST=0, Shift_En=1, accept 8'h0F.
  - Serial_Out = 0,0,0,0,1,1,1,1 over 8 cycles starting 1 cycle after the accept.
  - Frame_Start in cycle 1 only, Frame_Last in cycle 8 only, then IDLE_LEVEL.
- Same with LSB_FIRST=1, accept 8'h0F: Serial_Out = 1,1,1,1,0,0,0,0.
- Back-to-back 8'hA5 then 8'h3C with In_Valid held high.
  - Serial_Valid is high for 16 consecutive cycles with bits 10100101 00111100.
  - In_Ready is low while hold is full, and no word is lost or duplicated.
- Shift_En pulsed every 3rd cycle, accept 8'hC3: each bit is held for 3 cycles, and the frame spans 24 cycles after the first load.
- Back-pressure: a third word is presented while the shifter and hold are both full.
  - In_Ready=0 until the reload edge.
  - The word is accepted the cycle after In_Ready rises and is transmitted intact.
- Rst asserted at bit 4 of 8'hFF with a second word held.
  - Outputs immediately return to reset values.
  - After release, the line stays idle with Serial_Valid=0 until a new accept.
